// File: rtl/ic_stk_if.sv
// ic_stk_if: strobe/data bundle between the CPU control unit and the
// instruction counter. master = control unit, slave = ic_stk.
interface ic_stk_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] w;
  logic             inc;
  logic             inc2;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] ic;
  logic [LW-1:0]    lvl;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             err;

  modport master (
    output clr, ld, w, inc, inc2, push, pop,
    input  ic, lvl, full, empty, ovf, err
  );

  modport slave (
    input  clr, ld, w, inc, inc2, push, pop,
    output ic, lvl, full, empty, ovf, err
  );
endinterface

// File: rtl/ic_stk.sv
// ic_stk: instruction counter with clear/load/increment and a DEPTH-entry
// return-address stack for interrupt entry/exit.
// Build option: define IC_STACK_EN to implement the shadow stack; without it
// push/pop are ignored and lvl/full/empty/err are tied to their idle values.
module ic_stk #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic     clk_sys,
  input logic     rst_,
  ic_stk_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_ic;
  logic [WIDTH-1:0] w_ic_nxt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_top;
  logic             r_ovf;
  logic             w_inc_win;
  logic             w_pop_take;
  logic             w_pop_block;

  // Step is 1 or 2; the extra top bit captures the wrap carry.
  assign w_sum = {1'b0, r_ic} + {{(WIDTH-1){1'b0}}, bus.inc2, ~bus.inc2};

`ifdef IC_STACK_EN
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_stk [DEPTH];
  logic [LW-1:0]    r_lvl;
  logic [LW-1:0]    w_lvl_m1;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic             r_err;
  logic             w_both;
  logic             w_full;
  logic             w_empty;
  logic             w_pop_req;
  logic             w_push_ok;
  logic             w_push_err;

  assign w_both     = bus.push & bus.pop;
  assign w_full     = (r_lvl == LW'(DEPTH));
  assign w_empty    = (r_lvl == '0);
  // A pop only counts when clr/ld do not overrule it and no push collides.
  assign w_pop_req  = bus.pop & ~w_both & ~bus.clr & ~bus.ld;
  assign w_pop_take = w_pop_req & ~w_empty;
  assign w_pop_block = w_pop_req & w_empty;
  assign w_push_ok  = bus.push & ~w_both & ~w_full;
  assign w_push_err = bus.push & ~w_both & w_full;
  assign w_lvl_m1   = r_lvl - LW'(1);
  assign w_wr_idx   = r_lvl[AW-1:0];
  assign w_rd_idx   = w_lvl_m1[AW-1:0];
  assign w_top      = r_stk[w_rd_idx];

  // Stack occupancy and the one-cycle error pulse.
  always_ff @(posedge clk_sys or negedge rst_) begin
    if (!rst_) begin
      r_lvl <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_lvl <= r_lvl + LW'(1);
      end else if (w_pop_take) begin
        r_lvl <= w_lvl_m1;
      end
      r_err <= w_both | w_push_err | w_pop_block;
    end
  end

  // Stack storage: plain registers, never reset; the pre-edge IC is saved.
  always_ff @(posedge clk_sys) begin
    if (rst_ && w_push_ok) begin
      r_stk[w_wr_idx] <= r_ic;
    end
  end

  assign bus.lvl   = r_lvl;
  assign bus.full  = w_full;
  assign bus.empty = w_empty;
  assign bus.err   = r_err;
`else
  logic w_unused;

  assign w_unused    = ^{bus.push, bus.pop};
  assign w_pop_take  = 1'b0;
  assign w_pop_block = 1'b0;
  assign w_top       = '0;
  assign bus.lvl     = '0;
  assign bus.full    = 1'b0;
  assign bus.empty   = 1'b1;
  assign bus.err     = 1'b0;
`endif

  // IC source select: clr > ld > pop > inc > hold; an empty-stack pop holds.
  always_comb begin
    w_ic_nxt  = r_ic;
    w_inc_win = 1'b0;
    if (bus.clr) begin
      w_ic_nxt = '0;
    end else if (bus.ld) begin
      w_ic_nxt = bus.w;
    end else if (w_pop_take) begin
      w_ic_nxt = w_top;
    end else if (w_pop_block) begin
      w_ic_nxt = r_ic;
    end else if (bus.inc) begin
      w_ic_nxt  = w_sum[WIDTH-1:0];
      w_inc_win = 1'b1;
    end
  end

  // Counter register and wrap pulse.
  always_ff @(posedge clk_sys or negedge rst_) begin
    if (!rst_) begin
      r_ic  <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_ic  <= w_ic_nxt;
      r_ovf <= w_inc_win & w_sum[WIDTH];
    end
  end

  assign bus.ic  = r_ic;
  assign bus.ovf = r_ovf;
endmodule
